corefifo_wr_gray_ptr: RTL and testbench
=======================================

# corefifo_wr_gray_ptr

Write-side pointer and flag generator for the dual-clock CoreFIFO: the binary-to-Gray counterpart of the read-domain Gray decoder. It counts accepted writes in binary and drives the RAM write address. It also publishes a registered Gray-coded write pointer for the read-clock synchronizer, and decodes the already-synchronized read Gray pointer to produce full, almost-full, fill level and overflow in the write clock domain.

## Interface
- ADDRWIDTH, 3: RAM address width; FIFO depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits (extra wrap bit).
- AFULL_THRESH, 6: afull asserts when fill level >= this value; legal range 1..2^ADDRWIDTH.

- clk  in  1  write-domain clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset; one clock domain only.
- wr_en  in  1  write request.
- rd_ptr_gray_sync  in  ADDRWIDTH+1  read pointer, Gray-coded, already synchronized into clk domain.
- we_mem  out  ADDRWIDTH... no: we_mem  out  1  write accepted (wr_en & ~full), combinational, to RAM write enable.
- waddr  out  ADDRWIDTH  RAM write address = wbin[ADDRWIDTH-1:0].
- wptr_gray  out  ADDRWIDTH+1  registered Gray write pointer, for CDC to read domain.
- full  out  1  registered full flag.
- afull  out  1  registered almost-full flag.
- wr_level  out  ADDRWIDTH+1  registered fill level, 0..2^ADDRWIDTH.
- overflow  out  1  one-cycle registered pulse: write requested while full.

## Operation
- State: wbin (ADDRWIDTH+1 b binary), wptr_gray, full, afull, wr_level, overflow.
- Accept: we_mem = wr_en & ~full. On accept, wbin_next = wbin + 1 (mod 2^(ADDRWIDTH+1)); otherwise wbin_next = wbin.
- Gray encode: wgray_next = wbin_next ^ (wbin_next >> 1); registered into wptr_gray. No combinational path from wbin to the wptr_gray output.
- Read decode: rbin = Gray-to-binary of rd_ptr_gray_sync, MSB-first XOR chain.
- Level: level_next = (wbin_next - rbin) mod 2^(ADDRWIDTH+1); registered into wr_level.
- full_next = (wgray_next == {~rd_ptr_gray_sync[AW:AW-1], rd_ptr_gray_sync[AW-2:0]}), equivalent to level_next == 2^ADDRWIDTH. For ADDRWIDTH=1 the low slice is empty.
- afull_next = (level_next >= AFULL_THRESH).
- overflow_next = wr_en & full. The write is dropped and the pointer is not advanced.
- Reset: wbin, wptr_gray, wr_level = 0; full, afull, overflow = 0. Reset asserted mid-stream clears all state immediately (async); the first accept after release writes waddr 0.

## Timing
- we_mem and waddr are valid in the same cycle as wr_en; the RAM captures the data on that edge.
- waddr, wptr_gray, full, afull and wr_level reflect an accepted write one edge after it.
- Full is exact in the write domain: the write that fills the last slot raises full on the next cycle, so back-to-back writes never overrun.
- A read pointer change seen on rd_ptr_gray_sync clears full and decrements wr_level one edge later. This is pessimistic by the synchronizer latency, never optimistic.
- Simultaneous accepted write and read-pointer advance: level unchanged, full unchanged.
- Wrap-around: after 2^(ADDRWIDTH+1) accepts wbin returns to 0. wptr_gray changes exactly one bit per accept, including the wrap step (AW=3: 1000 -> 0000).
- wptr_gray never changes in a cycle without an accept.

## Structure
- Shared package corefifo_pkg: bin2gray function, gray2bin function, pointer-width constant PTRW = ADDRWIDTH+1.
- One sub-module: corefifo_gray_to_bin (ADDRWIDTH param) for the rbin decode. The encode is an inline package function.

## Test plan
All scenarios use ADDRWIDTH=3, AFULL_THRESH=6, with rd_ptr_gray_sync held at 0 unless stated.
- Reset release, idle: all outputs 0, waddr 0, wptr_gray 0000 for 10 cycles.
- 8 back-to-back writes: waddr steps 0..7; wptr_gray steps 0000,0001,0011,0010,0110,0111,0101,0100; afull rises after the 6th accept; full after the 8th; wr_level = 8.
- 9th write while full: we_mem = 0, waddr unchanged, overflow pulses exactly one cycle, wr_level stays 8.
- From full, set rd_ptr_gray_sync = 0011 (rbin 2): full drops next cycle, wr_level = 6, afull stays 1. Two further writes re-assert full.
- Continuous write and read for 40 accepts, read pointer trailing by 3: wptr_gray Hamming distance 1 per accept across the 1000 -> 0000 wrap; wr_level constant 3; full never set.
- Assert reset with wr_level = 5 mid-burst: all outputs go to 0 asynchronously before the next edge; the first post-reset accept has waddr 0.

Source files
------------

// File: rtl/corefifo_pkg.sv
// ---------------------------------------------------------------------------
// corefifo_pkg
// Shared definitions for the dual-clock CoreFIFO pointer logic.
//   - ADDRWIDTH_DFLT / PTRW : default address width and matching pointer width
//                             (ADDRWIDTH + 1, the extra bit is the wrap bit).
//   - bin2gray / gray2bin   : conversions on a zero-extended word. Zero upper
//                             bits do not disturb either conversion, so callers
//                             of any pointer width can use them and truncate
//                             the result.
// ---------------------------------------------------------------------------
package corefifo_pkg;

  localparam int ADDRWIDTH_DFLT = 3;
  localparam int PTRW           = ADDRWIDTH_DFLT + 1;

  localparam int GRAY_W = 32;
  typedef logic [GRAY_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // MSB-first XOR chain: each binary bit is the parity of every Gray bit at or
  // above its position.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = '0;
    for (int i = 0; i < GRAY_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/corefifo_wr_gray_ptr_if.sv
// ---------------------------------------------------------------------------
// corefifo_wr_gray_ptr_if
// Write-side bundle of the CoreFIFO pointer generator.
//   wr_en            write request from the producer
//   rd_ptr_gray_sync read Gray pointer, already synchronised to the write clock
//   we_mem           RAM write enable (write accepted this cycle)
//   waddr            RAM write address
//   wptr_gray        registered Gray write pointer, crosses to the read domain
//   full, afull      registered full / almost-full flags
//   wr_level         registered fill level, 0 .. 2^ADDRWIDTH
//   overflow         one-cycle pulse: write requested while full
// The slave modport is the pointer generator; the master modport is the
// producer / surrounding FIFO shell.
// ---------------------------------------------------------------------------
interface corefifo_wr_gray_ptr_if
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH = ADDRWIDTH_DFLT
);

  logic                 wr_en;
  logic [ADDRWIDTH:0]   rd_ptr_gray_sync;
  logic                 we_mem;
  logic [ADDRWIDTH-1:0] waddr;
  logic [ADDRWIDTH:0]   wptr_gray;
  logic                 full;
  logic                 afull;
  logic [ADDRWIDTH:0]   wr_level;
  logic                 overflow;

  modport master (
    output wr_en, rd_ptr_gray_sync,
    input  we_mem, waddr, wptr_gray, full, afull, wr_level, overflow
  );

  modport slave (
    input  wr_en, rd_ptr_gray_sync,
    output we_mem, waddr, wptr_gray, full, afull, wr_level, overflow
  );

endinterface

// File: rtl/corefifo_gray_to_bin.sv
// ---------------------------------------------------------------------------
// corefifo_gray_to_bin
// Combinational Gray-to-binary decoder for an (ADDRWIDTH+1)-bit FIFO pointer.
//   gray  in  ADDRWIDTH+1  Gray-coded pointer
//   bin   out ADDRWIDTH+1  binary equivalent
// ---------------------------------------------------------------------------
module corefifo_gray_to_bin
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH = ADDRWIDTH_DFLT
) (
  input  logic [ADDRWIDTH:0] gray,
  output logic [ADDRWIDTH:0] bin
);

  localparam int PW = ADDRWIDTH + 1;

  assign bin = PW'(gray2bin(GRAY_W'(gray)));

endmodule

// File: rtl/corefifo_wr_gray_ptr.sv
// ---------------------------------------------------------------------------
// corefifo_wr_gray_ptr
// Write-domain pointer and flag generator of the dual-clock CoreFIFO.
// Counts accepted writes in binary (wbin), drives the RAM write port, publishes
// a registered Gray write pointer for the read-domain synchroniser, and turns
// the synchronised read Gray pointer into full / afull / level / overflow.
//   clk    in  write clock, all state on the rising edge
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of corefifo_wr_gray_ptr_if (see interface header)
// Flags are pessimistic with respect to reads: a read only frees space once
// its pointer has crossed the synchroniser, never earlier.
// ---------------------------------------------------------------------------
module corefifo_wr_gray_ptr
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH    = ADDRWIDTH_DFLT,
  parameter int AFULL_THRESH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  corefifo_wr_gray_ptr_if.slave  bus
);

  localparam int PW = ADDRWIDTH + 1;

  // The full pattern of a Gray pointer pair: the write pointer equals the read
  // pointer with its two top bits inverted (one whole lap ahead). Expressed as
  // an XOR mask so the ADDRWIDTH=1 case needs no empty slice.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDRWIDTH - 1);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wptr_gray_q;
  logic [PW-1:0] wr_level_q;
  logic          full_q;
  logic          afull_q;
  logic          overflow_q;

  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] level_next;
  logic          accept;
  logic          full_next;

  corefifo_gray_to_bin #(
    .ADDRWIDTH (ADDRWIDTH)
  ) u_rd_decode (
    .gray (bus.rd_ptr_gray_sync),
    .bin  (rbin)
  );

  // A write while full is dropped here, so the pointer can never overrun.
  assign accept = bus.wr_en & ~full_q;

  // NOTE: every always_comb output gets a default at the top of the block so a
  // missed branch cannot infer a latch.
  always_comb begin
    wbin_next = wbin;
    if (accept) begin
      wbin_next = wbin + PW'(1);
    end
    wgray_next = PW'(bin2gray(GRAY_W'(wbin_next)));
    level_next = wbin_next - rbin;
    full_next  = (wgray_next == (bus.rd_ptr_gray_sync ^ FULL_MASK));
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin        <= '0;
      wptr_gray_q <= '0;
      wr_level_q  <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray_q <= wgray_next;
      wr_level_q  <= level_next;
      full_q      <= full_next;
      afull_q     <= (level_next >= AFULL_LVL);
      overflow_q  <= bus.wr_en & full_q;
    end
  end

  assign bus.we_mem    = accept;
  assign bus.waddr     = wbin[ADDRWIDTH-1:0];
  assign bus.wptr_gray = wptr_gray_q;
  assign bus.wr_level  = wr_level_q;
  assign bus.full      = full_q;
  assign bus.afull     = afull_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_corefifo_wr_gray_ptr.sv
// ---------------------------------------------------------------------------
// tb_corefifo_wr_gray_ptr
// Self-checking bench for corefifo_wr_gray_ptr with ADDRWIDTH=3,
// AFULL_THRESH=6. A directed vector table covers fill / overflow / drain,
// then hand sequences cover idle-after-reset, continuous streaming across the
// pointer wrap and asynchronous reset mid-burst, then a random run is
// compared against a counting model (write and read totals as plain ints).
// ---------------------------------------------------------------------------
module tb_corefifo_wr_gray_ptr;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic clk;
  logic reset;

  corefifo_wr_gray_ptr_if #(.ADDRWIDTH(AW)) bus ();

  corefifo_wr_gray_ptr #(
    .ADDRWIDTH    (AW),
    .AFULL_THRESH (AFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: total accepted writes and total reads as unbounded ints.
  int   m_wcount;
  int   m_level;
  logic m_full;
  logic m_afull;
  logic m_ovf;

  function automatic logic [3:0] to_gray(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m / 2));
  endfunction

  task automatic model_reset();
    m_wcount = 0;
    m_level  = 0;
    m_full   = 1'b0;
    m_afull  = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the same-cycle RAM port, clock,
  // advance the model and check every registered output.
  task automatic step(input logic wr, input int rcount);
    logic acc;
    bus.wr_en            = wr;
    bus.rd_ptr_gray_sync = to_gray(rcount);
    #1;
    acc = wr && !m_full;
    check("we_mem", 32'(bus.we_mem), 32'(acc));
    check("waddr_pre", 32'(bus.waddr), 32'(m_wcount % DEPTH));
    @(posedge clk);
    #1;
    m_ovf    = wr && m_full;
    m_wcount = m_wcount + (acc ? 1 : 0);
    m_level  = m_wcount - rcount;
    m_full   = (m_level == DEPTH);
    m_afull  = (m_level >= AFT);
    check("waddr",     32'(bus.waddr),     32'(m_wcount % DEPTH));
    check("wptr_gray", 32'(bus.wptr_gray), 32'(to_gray(m_wcount)));
    check("wr_level",  32'(bus.wr_level),  32'(m_level));
    check("full",      32'(bus.full),      32'(m_full));
    check("afull",     32'(bus.afull),     32'(m_afull));
    check("overflow",  32'(bus.overflow),  32'(m_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_waddr"},     32'(bus.waddr),     32'd0);
    check({tag, "_wptr_gray"}, 32'(bus.wptr_gray), 32'd0);
    check({tag, "_wr_level"},  32'(bus.wr_level),  32'd0);
    check({tag, "_full"},      32'(bus.full),      32'd0);
    check({tag, "_afull"},     32'(bus.afull),     32'd0);
    check({tag, "_overflow"},  32'(bus.overflow),  32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_ptr_gray_sync = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] rg;
    logic       we;
    logic [2:0] waddr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] level;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];
  int   rcount;
  logic [3:0] prev_gray;

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_ptr_gray_sync = '0;

    //            wr  rg       we  waddr gray    full afull level  ovf
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0});
    // 9th write while full: dropped, overflow pulse
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0});
    // read pointer moves to Gray 0011 (binary 2)
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b1, 4'd6, 1'b0});
    tbl.push_back('{1'b1, 4'b0011, 1'b1, 3'd1, 4'b1101, 1'b0, 1'b1, 4'd7, 1'b0});
    tbl.push_back('{1'b1, 4'b0011, 1'b1, 3'd2, 4'b1111, 1'b1, 1'b1, 4'd8, 1'b0});
    tbl.push_back('{1'b1, 4'b0011, 1'b0, 3'd2, 4'b1111, 1'b1, 1'b1, 4'd8, 1'b1});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 3'd2, 4'b1111, 1'b1, 1'b1, 4'd8, 1'b0});

    do_reset();

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      bus.wr_en            = tbl[i].wr;
      bus.rd_ptr_gray_sync = tbl[i].rg;
      #1;
      check("tbl_we_mem", 32'(bus.we_mem), 32'(tbl[i].we));
      @(posedge clk);
      #1;
      check("tbl_waddr",     32'(bus.waddr),     32'(tbl[i].waddr));
      check("tbl_wptr_gray", 32'(bus.wptr_gray), 32'(tbl[i].gray));
      check("tbl_full",      32'(bus.full),      32'(tbl[i].full));
      check("tbl_afull",     32'(bus.afull),     32'(tbl[i].afull));
      check("tbl_wr_level",  32'(bus.wr_level),  32'(tbl[i].level));
      check("tbl_overflow",  32'(bus.overflow),  32'(tbl[i].ovf));
    end

    // Idle for 10 cycles after reset release
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 0);

    // Continuous stream, read pointer trailing by 3, across both pointer wraps
    for (int i = 0; i < 3; i++) step(1'b1, 0);
    rcount = 0;
    for (int i = 0; i < 40; i++) begin
      prev_gray = bus.wptr_gray;
      rcount++;
      step(1'b1, rcount);
      check("hamming", 32'($countones(prev_gray ^ bus.wptr_gray)), 32'd1);
    end

    // Asynchronous reset mid-burst at level 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 0);
    bus.wr_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 0);

    // Random stream against the counting model
    do_reset();
    rcount = 0;
    for (int i = 0; i < 400; i++) begin
      logic wr;
      wr = ($urandom_range(0, 99) < 60);
      if (rcount < m_wcount && $urandom_range(0, 99) < 45) rcount++;
      step(wr, rcount);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
